// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-side arbiter: FSM encoding,
// statistics counter width and the grant-index width helper.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam int STAT_W = 16;

  // Index width for n requesters; never below one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set req_valid bit searching upward from
// rr_ptr, wrapping modulo NUM_REQ. Purely combinational.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    pick,
  output logic               any_valid
);

  // Scan NUM_REQ positions starting at rr_ptr; the first hit wins.
  always_comb begin
    int idx;
    idx       = 0;
    pick      = '0;
    any_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_valid && req_valid[idx]) begin
        pick      = ID_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side scheduler for the async FIFO: shares the single FIFO write
// port between NUM_REQ requesters with round-robin bursts of up to
// MAX_BURST words. Optional per-requester word counters are built when
// FIFO_ARB_STATS_EN is defined; otherwise stat_cnt is tied to zero.
//
// Handshake: a word moves from requester i to the FIFO on a wr_clk edge
// exactly when req_valid[i] && req_ready[i]. req_ready never depends on
// anything but the registered grant, req_valid of the granted requester
// and fifo_full, so fifo_wr_en == |req_ready always. A requester must
// hold req_data stable while valid && !ready; dropping valid mid-burst
// ends the burst with no write.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 4,
  parameter  int MAX_BURST  = 4,
  localparam int ID_W       = id_width(NUM_REQ)
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  output logic [NUM_REQ*STAT_W-1:0]     stat_cnt,
  output state_t                        dbg_state
);

  localparam int BC_W = $clog2(MAX_BURST) + 1;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   grant_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]   beat_q, beat_d;
  logic [ID_W-1:0]   pick;
  logic              any_valid;
  logic              xfer;
  logic              burst_end;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .pick      (pick),
    .any_valid (any_valid)
  );

  assign busy         = (state_q == ST_BURST);
  assign dbg_state    = state_q;
  assign xfer         = busy && req_valid[grant_id] && !fifo_full;
  assign req_ready    = xfer ? (NUM_REQ'(1) << grant_id) : '0;
  assign fifo_wr_en   = xfer;
  assign fifo_wr_data = busy ? req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign burst_end    = busy && (!req_valid[grant_id] ||
                                 (xfer && (beat_q == BC_W'(MAX_BURST - 1))));

  // Next-state: arbitrate in IDLE, count beats and rotate the pointer in BURST.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_id;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          grant_d = pick;
          beat_d  = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (burst_end) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end else if (xfer) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, grant, pointer and beat counter registers.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q  <= ST_IDLE;
      grant_id <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_id <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [STAT_W-1:0] cnt_q;
    // Saturating count of words accepted from requester i.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n)
        cnt_q <= '0;
      else if (xfer && (grant_id == ID_W'(i)) && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
    end
    assign stat_cnt[i*STAT_W +: STAT_W] = cnt_q;
  end
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter. Each requester is a queue of
// words; the expected FIFO write stream is derived burst-by-burst from the
// round-robin rules and compared against every observed write.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int MB = 4;

  logic              wr_clk = 1'b0;
  logic              wr_rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      req_ready;
  logic              fifo_full = 1'b0;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_wr_data;
  logic [1:0]        grant_id;
  logic              busy;
  logic [N*16-1:0]   stat_cnt;
  state_t            dbg_state;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] src_q [N][$];
  logic [N-1:0]  en = '1;
  logic [5:0]    exp_q[$];
  int            wcyc_q[$];
  int            mdl_ptr = 0;
  int            cyc = 0;
  bit            rand_full = 1'b0;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wr_clk       (wr_clk),
    .wr_rst_n     (wr_rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_id     (grant_id),
    .busy         (busy),
    .stat_cnt     (stat_cnt),
    .dbg_state    (dbg_state)
  );

  // Clock / watchdog
  always #5 wr_clk = ~wr_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: present the head of each requester queue.
  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = en[i] && (src_q[i].size() > 0);
      req_data[i*DW +: DW]  = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
  endtask

  // One clock: sample at negedge, check, then update inputs after the edge.
  task automatic cycle();
    logic [N-1:0]  rdy;
    logic          we;
    logic [DW-1:0] wd;
    logic [1:0]    id;
    logic [31:0]   e;
    @(negedge wr_clk);
    rdy = req_ready;
    we  = fifo_wr_en;
    wd  = fifo_wr_data;
    id  = '0;
    for (int i = 0; i < N; i++) if (rdy[i]) id = 2'(i);
    chk("ready_onehot0", 32'($onehot0(rdy)), 32'd1);
    chk("wr_en_eq_ready", 32'(we), 32'(|rdy));
    if (fifo_full) chk("no_write_when_full", 32'(we), 32'd0);
    if (we) begin
      wcyc_q.push_back(cyc);
      e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD;
      chk("write_id_data", {26'd0, id, wd}, e);
    end
    @(posedge wr_clk);
    #1;
    cyc++;
    if (we) void'(src_q[id].pop_front());
    if (rand_full) fifo_full = ($urandom_range(0, 99) < 30);
    apply_inputs();
  endtask

  // Reference model: whole-burst round robin over requesters with words left.
  task automatic build_exp();
    int rem[N];
    int pos[N];
    int total;
    int g;
    int n;
    total = 0;
    for (int i = 0; i < N; i++) begin
      rem[i] = src_q[i].size();
      pos[i] = 0;
      total += rem[i];
    end
    while (total > 0) begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && rem[(mdl_ptr + k) % N] > 0) g = (mdl_ptr + k) % N;
      n = (rem[g] < MB) ? rem[g] : MB;
      for (int j = 0; j < n; j++) exp_q.push_back({2'(g), src_q[g][pos[g] + j]});
      pos[g] += n;
      rem[g] -= n;
      total  -= n;
      mdl_ptr = (g + 1) % N;
    end
  endtask

  function automatic bit srcs_left();
    bit any;
    any = 1'b0;
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) any = 1'b1;
    return any;
  endfunction

  task automatic drain();
    int budget;
    budget = 0;
    while ((exp_q.size() > 0 || busy || srcs_left()) && budget < 600) begin
      cycle();
      budget++;
    end
    chk("drain_in_budget", 32'(budget < 600), 32'd1);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic load(input int id, input int nwords);
    for (int j = 0; j < nwords; j++) src_q[id].push_back(DW'($urandom_range(0, 15)));
  endtask

  task automatic do_reset();
    wr_rst_n = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    en = '1;
    fifo_full = 1'b0;
    apply_inputs();
    repeat (2) @(posedge wr_clk);
    #1;
    wr_rst_n = 1'b1;
    mdl_ptr = 0;
  endtask

  initial begin
    int c0;
    int guard;
    int exp_off[10];
    exp_off = '{1, 2, 3, 4, 6, 7, 8, 9, 11, 12};

    // Reset values
    do_reset();
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_wr_data", 32'(fifo_wr_data), 32'd0);
    chk("rst_stat_cnt", 32'(|stat_cnt), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Single requester, 10 words: bursts 4,4,2 with one-cycle bubbles
    load(0, 10);
    build_exp();
    wcyc_q.delete();
    c0 = cyc;
    apply_inputs();
    drain();
    chk("single_nwrites", 32'(wcyc_q.size()), 32'd10);
    for (int k = 0; k < 10 && k < wcyc_q.size(); k++)
      chk("single_write_cycle", 32'(wcyc_q[k] - c0), 32'(exp_off[k]));

    // Round robin: all four valid, grant order 0,1,2,3,0,...
    do_reset();
    for (int i = 0; i < N; i++) load(i, 5);
    build_exp();
    apply_inputs();
    drain();

    // Full stall after beat 2 of requester 1's burst
    do_reset();
    load(1, 6);
    load(2, 2);
    build_exp();
    wcyc_q.delete();
    apply_inputs();
    guard = 0;
    while (wcyc_q.size() < 2 && guard < 50) begin
      cycle();
      guard++;
    end
    chk("stall_reach_beat2", 32'(wcyc_q.size()), 32'd2);
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("stall_grant_held", 32'(grant_id), 32'd1);
      chk("stall_busy", 32'(busy), 32'd1);
    end
    chk("stall_no_writes", 32'(wcyc_q.size()), 32'd2);
    fifo_full = 1'b0;
    drain();

    // Early release: requester 3 drops valid after one word
    load(3, 3);
    exp_q.push_back({2'd3, src_q[3][0]});
    wcyc_q.delete();
    apply_inputs();
    guard = 0;
    while (wcyc_q.size() < 1 && guard < 50) begin
      cycle();
      guard++;
    end
    chk("early_first_word", 32'(wcyc_q.size()), 32'd1);
    chk("early_grant", 32'(grant_id), 32'd3);
    en[3] = 1'b0;
    apply_inputs();
    cycle();
    chk("early_burst_ended", 32'(busy), 32'd0);
    chk("early_no_extra_write", 32'(wcyc_q.size()), 32'd1);
    load(0, 2);
    load(2, 1);
    en[3] = 1'b1;
    mdl_ptr = 0;
    build_exp();
    apply_inputs();
    drain();

    // Randomized traffic with random fifo_full
    rand_full = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) load(i, $urandom_range(0, 9));
      build_exp();
      apply_inputs();
      drain();
    end
    rand_full = 1'b0;
    fifo_full = 1'b0;
    apply_inputs();

`ifdef FIFO_ARB_STATS_EN
    // Statistics counters and saturation
    do_reset();
    load(0, 7);
    load(1, 3);
    build_exp();
    apply_inputs();
    drain();
    chk("stat0_7", 32'(stat_cnt[0 +: 16]), 32'd7);
    chk("stat1_3", 32'(stat_cnt[16 +: 16]), 32'd3);
    force dut.g_stat[0].cnt_q = 16'hFFFE;
    #1;
    release dut.g_stat[0].cnt_q;
    #1;
    chk("stat0_forced", 32'(stat_cnt[0 +: 16]), 32'hFFFE);
    load(0, 3);
    build_exp();
    apply_inputs();
    drain();
    chk("stat0_saturate", 32'(stat_cnt[0 +: 16]), 32'hFFFF);
`else
    chk("stat_tied_zero", 32'(|stat_cnt), 32'd0);
`endif

    // Reset asserted during requester 2's burst
    do_reset();
    load(2, 8);
    build_exp();
    wcyc_q.delete();
    apply_inputs();
    guard = 0;
    while (wcyc_q.size() < 2 && guard < 50) begin
      cycle();
      guard++;
    end
    #2;
    chk("pre_reset_grant", 32'(grant_id), 32'd2);
    chk("pre_reset_wr_en", 32'(fifo_wr_en), 32'd1);
    wr_rst_n = 1'b0;
    #1;
    chk("reset_wr_en_drop", 32'(fifo_wr_en), 32'd0);
    chk("reset_ready_drop", 32'(req_ready), 32'd0);
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    apply_inputs();
    repeat (2) @(posedge wr_clk);
    #1;
    wr_rst_n = 1'b1;
    #1;
    chk("post_reset_grant", 32'(grant_id), 32'd0);
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_stat", 32'(|stat_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
